io_bus_arbiter: RTL

- Two-master, round-robin arbiter for the shared 16-bit DMA/IO slave bus. That bus carries systolic36 register/DMA space and io_led.
- Master 0 is the CPU core's IO port. Master 1 is a second bus master, such as the UART debug monitor or a future DMA engine.
- The arbiter drives one slave-side bus and routes 1-cycle-latency read data back to the master that issued the read.
- Bounded bursts keep either master from starving the other.

---
 rtl/io_bus_arbiter.sv | 79 +++++++
 1 files changed

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: two-master round-robin arbiter for the shared 16-bit DMA/IO slave bus
module io_bus_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [13:0] m0_adr,
  input  logic [15:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [15:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [13:0] m1_adr,
  input  logic [15:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [15:0] m1_rdata,
  output logic        dma_io_we,
  output logic [13:0] dma_io_wadr,
  output logic [15:0] dma_io_wdata,
  output logic [13:0] dma_io_radr,
  input  logic [15:0] dma_io_rdata
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  localparam logic [3:0] LAST = 4'(MAX_BURST - 1);
  state_t      state;
  logic [3:0]  burst_cnt;
  logic        last_served, rd_pend, rd_owner;
  logic        cur, own_req, oth_req, beat, we_sel;
  logic [13:0] adr_sel;
  logic [15:0] wdata_sel;
  assign m0_gnt    = state == GNT0;
  assign m1_gnt    = state == GNT1;
  assign m0_rvalid = rd_pend & ~rd_owner;
  assign m1_rvalid = rd_pend & rd_owner;
  assign m0_rdata  = m0_rvalid ? dma_io_rdata : '0;
  assign m1_rdata  = m1_rvalid ? dma_io_rdata : '0;
  // Route the current owner's qualifiers to the slave; IDLE drives zeros
  always_comb begin
    cur          = state == GNT1;
    own_req      = cur ? m1_req : m0_req;
    oth_req      = cur ? m0_req : m1_req;
    beat         = (state != IDLE) & own_req;
    we_sel       = (state == IDLE) ? 1'b0 : cur ? m1_we : m0_we;
    adr_sel      = (state == IDLE) ? '0 : cur ? m1_adr : m0_adr;
    wdata_sel    = (state == IDLE) ? '0 : cur ? m1_wdata : m0_wdata;
    dma_io_we    = beat & we_sel;
    dma_io_wadr  = adr_sel;
    dma_io_radr  = adr_sel;
    dma_io_wdata = wdata_sel;
  end
  // Grant FSM with bounded bursts, plus read-return tagging for the 1-cycle slave
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      burst_cnt   <= '0;
      last_served <= 1'b1;
      rd_pend     <= 1'b0;
      rd_owner    <= 1'b0;
    end else begin
      rd_pend  <= beat & ~we_sel;
      rd_owner <= cur;
      if (state == IDLE) begin
        burst_cnt <= '0;
        if (m0_req & (~m1_req | last_served)) state <= GNT0;
        else if (m1_req) state <= GNT1;
      end else if (!own_req || (burst_cnt == LAST && oth_req)) begin
        last_served <= cur;
        burst_cnt   <= '0;
        state       <= oth_req ? (cur ? GNT0 : GNT1) : IDLE;
      end else if (burst_cnt != LAST) begin
        burst_cnt <= burst_cnt + 4'd1;
      end
    end
  end
endmodule
